// File: rtl/sad_min_select_if.sv
// Handshake and result bundle between the SAD engine, sad_min_select and the
// motion-vector control logic. The slave side is the selector itself.
interface sad_min_select_if #(
  parameter int SAD_W = 32,
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] num_cand;
  logic [SAD_W-1:0] thresh;
  logic [SAD_W-1:0] sad_in;
  logic             sad_valid;
  logic             sad_ready;
  logic             busy;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             early;
  logic             done;
  logic [1:0]       state_dbg;

  // sad_in is transferred on a rising clk edge where sad_valid and sad_ready
  // are both high; sad_ready depends only on state, never on sad_valid.
  modport master (
    output start, num_cand, thresh, sad_in, sad_valid,
    input  sad_ready, busy, best_sad, best_idx, early, done, state_dbg
  );

  modport slave (
    input  start, num_cand, thresh, sad_in, sad_valid,
    output sad_ready, busy, best_sad, best_idx, early, done, state_dbg
  );
endinterface

// File: rtl/sad_min_select.sv
// Minimum-SAD selector: scans one search window of SAD results, keeps the
// smallest value and its arrival index, and optionally stops on a threshold hit.
module sad_min_select #(
  parameter int SAD_W = 32,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sad_min_select_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] num_lat;
  logic [SAD_W-1:0] thr_lat;
  logic [SAD_W-1:0] best_sad_r;
  logic [IDX_W-1:0] best_idx_r;
  logic             early_r;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;

  logic take;
  logic hit;
  logic last;

  // The first sample of a search always wins so an all-ones SAD is recorded.
  assign take = (cnt == '0) || (bus.sad_in < best_sad_r);
  assign hit  = (thr_lat != '1) && (bus.sad_in <= thr_lat);
  assign last = (cnt == num_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      num_lat    <= '0;
      thr_lat    <= '0;
      best_sad_r <= '1;
      best_idx_r <= '0;
      early_r    <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            num_lat <= bus.num_cand;
            thr_lat <= bus.thresh;
            cnt     <= '0;
            early_r <= 1'b0;
            state   <= SCAN;
            busy_r  <= 1'b1;
            ready_r <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.sad_valid) begin
            if (take) begin
              best_sad_r <= bus.sad_in;
              best_idx_r <= cnt;
            end
            if (hit || last) begin
              early_r <= hit;
              state   <= DONE;
              done_r  <= 1'b1;
              ready_r <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sad_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.best_sad  = best_sad_r;
  assign bus.best_idx  = best_idx_r;
  assign bus.early     = early_r;
  assign bus.done      = done_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: a driver issues searches and pushes the
// hand-computed result; a monitor pops and compares on every done pulse.
module tb_sad_min_select;
  localparam int SAD_W = 32;
  localparam int IDX_W = 8;
  localparam int EW    = SAD_W + IDX_W + 1;
  localparam logic [SAD_W-1:0] ONES = '1;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [EW-1:0] exp_q[$];

  sad_min_select_if #(.SAD_W(SAD_W), .IDX_W(IDX_W)) bus ();

  sad_min_select #(.SAD_W(SAD_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("best_sad", 64'(bus.best_sad), 64'(e[EW-1 -: SAD_W]));
        check("best_idx", 64'(bus.best_idx), 64'(e[IDX_W:1]));
        check("early",    64'(bus.early),    64'(e[0]));
      end
    end
  end

  // driver tasks (all drive at negedge)
  task automatic push_exp(input logic [SAD_W-1:0] s, input logic [IDX_W-1:0] i, input logic e);
    exp_q.push_back({s, i, e});
  endtask

  task automatic do_start(input logic [IDX_W-1:0] n, input logic [SAD_W-1:0] t);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("start_wait_timeout", 64'd1, 64'd0);
    bus.start    = 1'b1;
    bus.num_cand = n;
    bus.thresh   = t;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [SAD_W-1:0] v);
    int k = 0;
    while (bus.sad_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("ready_timeout", 64'd1, 64'd0);
    bus.sad_valid = 1'b1;
    bus.sad_in    = v;
    @(negedge clk);
    bus.sad_valid = 1'b0;
  endtask

  logic       stall_v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] stall_d[6] = '{8'd8, 8'd99, 8'd99, 8'd5, 8'd99, 8'd6};

  initial begin
    bus.start = 1'b0; bus.num_cand = '0; bus.thresh = '0;
    bus.sad_in = '0;  bus.sad_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_best_sad", 64'(bus.best_sad), 64'(ONES));
    check("rst_best_idx", 64'(bus.best_idx), 64'd0);
    check("rst_early",    64'(bus.early), 64'd0);
    check("rst_done",     64'(bus.done), 64'd0);
    check("rst_busy",     64'(bus.busy), 64'd0);
    check("rst_ready",    64'(bus.sad_ready), 64'd0);
    check("rst_state",    64'(bus.state_dbg), 64'd0);

    // basic minimum, back-to-back
    push_exp(32'd25, 8'd1, 1'b0);
    do_start(8'd3, ONES);
    send(32'd40); send(32'd25); send(32'd90); send(32'd30);
    check("basic_done_latency", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("basic_done_width", 64'(bus.done), 64'd0);

    // ties keep earlier index; all-ones first sample
    push_exp(32'd7, 8'd1, 1'b0);
    do_start(8'd2, ONES);
    send(ONES); send(32'd7); send(32'd7);
    push_exp(ONES, 8'd0, 1'b0);
    do_start(8'd0, ONES);
    send(ONES);
    check("single_done_latency", 64'(bus.done), 64'd1);

    // early exit; extra sample and start in DONE are ignored
    push_exp(32'd9, 8'd2, 1'b1);
    do_start(8'd9, 32'd10);
    send(32'd50); send(32'd12); send(32'd9);
    check("early_done", 64'(bus.done), 64'd1);
    check("early_ready_in_done", 64'(bus.sad_ready), 64'd0);
    bus.sad_valid = 1'b1; bus.sad_in = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_in_done_busy", 64'(bus.busy), 64'd0);
    check("start_in_done_ready", 64'(bus.sad_ready), 64'd0);
    repeat (2) @(negedge clk);
    bus.sad_valid = 1'b0;
    check("early_not_consumed", 64'(bus.best_sad), 64'd9);

    // threshold equality hits on an exact match
    push_exp(32'd20, 8'd1, 1'b1);
    do_start(8'd4, 32'd20);
    send(32'd30); send(32'd20);

    // stalls, with start pulsed mid-scan
    push_exp(32'd5, 8'd1, 1'b0);
    do_start(8'd2, ONES);
    for (int c = 0; c < 6; c++) begin
      bus.sad_valid = stall_v[c];
      bus.sad_in    = 32'(stall_d[c]);
      bus.start     = (c == 2);
      bus.num_cand  = '0;
      @(negedge clk);
    end
    bus.sad_valid = 1'b0; bus.start = 1'b0;
    check("stall_done_latency", 64'(bus.done), 64'd1);

    // reset mid-search aborts without done
    do_start(8'd7, ONES);
    send(32'd11); send(32'd12); send(32'd13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_best_sad", 64'(bus.best_sad), 64'(ONES));
    check("abort_best_idx", 64'(bus.best_idx), 64'd0);
    check("abort_busy",     64'(bus.busy), 64'd0);
    check("abort_done",     64'(bus.done), 64'd0);
    push_exp(32'd4, 8'd1, 1'b0);
    do_start(8'd1, ONES);
    send(32'd6); send(32'd4);

    // full window of 256 candidates
    push_exp(32'd745, 8'd255, 1'b0);
    do_start(8'd255, ONES);
    for (int i = 0; i < 256; i++) begin
      send(32'(1000 - i));
      if (i < 255) check("full_no_early_done", 64'(bus.done), 64'd0);
    end
    check("full_done_latency", 64'(bus.done), 64'd1);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
